window_filter: RTL and testbench

Parametrised 3x3 neighbourhood filter stage for the image filter pipeline. It buffers two video lines and forms a 3x3 window on a streamed grey pixel feed. Per frame it applies one of four modes: bypass, Gaussian blur, Sobel edge magnitude or 3x3 dilate. It fills the blur and edge-detection slots between the greyscale/threshold stages, with a fixed latency so that bypass and filtered paths stay aligned.

---
 rtl/window_filter.sv | 215 +++++++++++++++++++++
 tb/tb_window_filter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/window_filter.sv
// 3x3 neighbourhood filter: two line buffers feed a 3x3 window, then bypass, blur, Sobel
// magnitude or dilate selected per frame. Fixed three-cycle latency from pixel in to pixel out.
module window_filter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LINE_W = 640,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              VSync,
   input  logic              HSync,
   input  logic [1:0]        Mode,
   input  logic              PixValid,
   input  logic [DATA_W-1:0] PixIn,
   output logic              OutValid,
   output logic [DATA_W-1:0] PixOut,
   output logic              Overflow
);

   localparam logic [1:0] ModeBypass = 2'b00;
   localparam logic [1:0] ModeBlur   = 2'b01;
   localparam logic [1:0] ModeEdge   = 2'b10;
   localparam logic [1:0] ModeDilate = 2'b11;

   localparam int unsigned SW     = DATA_W + 4;
   localparam int unsigned EW     = DATA_W + 3;
   localparam int unsigned MemAw  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [ADDR_W-1:0] ColMax = ADDR_W'(LINE_W);
   localparam logic [EW-1:0]     PixMax = EW'({DATA_W{1'b1}});

   // Line position and per-frame state
   logic [ADDR_W-1:0] col_q, col_d, col_cur;
   logic [1:0]        row_q, row_d, row_cur;
   logic [1:0]        mode_q, mode_cur;
   logic              line_pix_q, line_pix_d;
   logic              overflow_q, overflow_d;
   logic              in_range;
   logic [1:0]        win_min;
   logic              zero_cur;

   // A pixel arriving with a sync pulse belongs to the new line/frame, so
   // all decisions use the post-sync position.
   always_comb begin
      col_cur    = col_q;
      row_cur    = row_q;
      mode_cur   = mode_q;
      line_pix_d = line_pix_q;
      overflow_d = overflow_q;
      if (VSync) begin
         col_cur    = '0;
         row_cur    = '0;
         mode_cur   = Mode;
         line_pix_d = 1'b0;
         overflow_d = 1'b0;
      end else if (HSync) begin
         col_cur    = '0;
         line_pix_d = 1'b0;
         if (line_pix_q && (row_q != 2'd2)) begin
            row_cur = row_q + 2'd1;
         end
      end
      in_range = (col_cur < ColMax);
      col_d    = col_cur;
      row_d    = row_cur;
      if (PixValid) begin
         line_pix_d = 1'b1;
         if (in_range) begin
            col_d = col_cur + ADDR_W'(1);
         end else begin
            overflow_d = 1'b1;
         end
      end
      win_min  = (mode_cur == ModeBypass) ? 2'd1 : 2'd2;
      zero_cur = !in_range || (row_cur < win_min) || (col_cur < ADDR_W'(win_min));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         col_q      <= '0;
         row_q      <= '0;
         mode_q     <= ModeBypass;
         line_pix_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         mode_q     <= mode_cur;
         line_pix_q <= line_pix_d;
         overflow_q <= overflow_d;
      end
   end

   assign Overflow = overflow_q;

   // Line buffers: lb1 holds the previous line, lb2 the one before. Read-before-write
   // at the current column shifts each column down one line.
   logic [DATA_W-1:0] lb1_mem [LINE_W];
   logic [DATA_W-1:0] lb2_mem [LINE_W];
   logic [MemAw-1:0]  mem_addr;
   logic [DATA_W-1:0] lb1_rd, lb2_rd;
   logic [DATA_W-1:0] rd1_q, rd2_q, s1_pix_q;

   always_comb begin
      mem_addr = col_cur[MemAw-1:0];
      lb1_rd   = in_range ? lb1_mem[mem_addr] : '0;
      lb2_rd   = in_range ? lb2_mem[mem_addr] : '0;
   end

   always_ff @(posedge CLK) begin
      if (PixValid && !RST) begin
         rd1_q    <= lb1_rd;
         rd2_q    <= lb2_rd;
         s1_pix_q <= PixIn;
         if (in_range) begin
            lb1_mem[mem_addr] <= PixIn;
            lb2_mem[mem_addr] <= lb1_rd;
         end
      end
   end

   // Pipeline control alongside the data
   logic       s1_valid_q, s1_zero_q, s2_valid_q, s2_zero_q;
   logic [1:0] s1_mode_q, s2_mode_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s1_zero_q  <= 1'b0;
         s1_mode_q  <= ModeBypass;
         s2_valid_q <= 1'b0;
         s2_zero_q  <= 1'b0;
         s2_mode_q  <= ModeBypass;
      end else begin
         s1_valid_q <= PixValid;
         s1_zero_q  <= zero_cur;
         s1_mode_q  <= mode_cur;
         s2_valid_q <= s1_valid_q;
         s2_zero_q  <= s1_zero_q;
         s2_mode_q  <= s1_mode_q;
      end
   end

   // win_q[row][col]: row 0 = two lines up, col 2 = newest column
   logic [DATA_W-1:0] win_q [3][3];

   always_ff @(posedge CLK) begin
      if (s1_valid_q) begin
         for (int i = 0; i < 3; i++) begin
            win_q[i][0] <= win_q[i][1];
            win_q[i][1] <= win_q[i][2];
         end
         win_q[0][2] <= rd2_q;
         win_q[1][2] <= rd1_q;
         win_q[2][2] <= s1_pix_q;
      end
   end

   function automatic logic [SW-1:0] ux(input logic [DATA_W-1:0] v);
      return {{(SW - DATA_W){1'b0}}, v};
   endfunction

   function automatic logic signed [EW-1:0] sx(input logic [DATA_W-1:0] v);
      return $signed({{(EW - DATA_W){1'b0}}, v});
   endfunction

   logic [SW-1:0]        blur_sum;
   logic signed [EW-1:0] gx, gy;
   logic [EW-1:0]        ax, ay, mag;
   logic [DATA_W-1:0]    edge_pix, dmax, filt;

   always_comb begin
      blur_sum = ux(win_q[0][0]) + (ux(win_q[0][1]) << 1) + ux(win_q[0][2])
               + (ux(win_q[1][0]) << 1) + (ux(win_q[1][1]) << 2) + (ux(win_q[1][2]) << 1)
               + ux(win_q[2][0]) + (ux(win_q[2][1]) << 1) + ux(win_q[2][2]);

      gx = (sx(win_q[0][2]) + (sx(win_q[1][2]) <<< 1) + sx(win_q[2][2]))
         - (sx(win_q[0][0]) + (sx(win_q[1][0]) <<< 1) + sx(win_q[2][0]));
      gy = (sx(win_q[2][0]) + (sx(win_q[2][1]) <<< 1) + sx(win_q[2][2]))
         - (sx(win_q[0][0]) + (sx(win_q[0][1]) <<< 1) + sx(win_q[0][2]));
      ax  = gx[EW-1] ? -gx : gx;
      ay  = gy[EW-1] ? -gy : gy;
      mag = ax + ay;
      edge_pix = (mag > PixMax) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];

      dmax = '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            if (win_q[i][j] > dmax) begin
               dmax = win_q[i][j];
            end
         end
      end

      unique case (s2_mode_q)
         ModeBypass: filt = win_q[1][1];
         ModeBlur:   filt = blur_sum[DATA_W+3:4];
         ModeEdge:   filt = edge_pix;
         ModeDilate: filt = dmax;
         default:    filt = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         OutValid <= 1'b0;
         PixOut   <= '0;
      end else begin
         OutValid <= s2_valid_q;
         if (s2_valid_q) begin
            PixOut <= s2_zero_q ? '0 : filt;
         end
      end
   end

endmodule

// File: tb/tb_window_filter.sv
// Randomised bench for window_filter: a frame-image reference model predicts every output,
// its arrival cycle, the held value between outputs and the Overflow flag.
module tb_window_filter;

   localparam int DW = 8;
   localparam int LW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          vsync = 1'b0;
   logic          hsync = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          pix_valid = 1'b0;
   logic [DW-1:0] pix_in = '0;
   logic          out_valid;
   logic [DW-1:0] pix_out;
   logic          overflow;

   window_filter #(
      .DATA_W(DW),
      .LINE_W(LW),
      .ADDR_W(AW)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .VSync   (vsync),
      .HSync   (hsync),
      .Mode    (mode),
      .PixValid(pix_valid),
      .PixIn   (pix_in),
      .OutValid(out_valid),
      .PixOut  (pix_out),
      .Overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int due;
      int val;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   last_exp = 0;
   bit   ovf_shown = 1'b0;
   bit   m_ovf = 1'b0;
   bit   rst_prev = 1'b1;
   bit   mon_en = 1'b0;

   // Reference model: pixels of the current frame indexed by (line, column)
   int img[16][16];
   int m_r = 0;
   int m_c = 0;
   int m_mode = 0;
   bit m_has = 1'b0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int model_pix(input int r, input int c, input int md);
      int k;
      int p[3][3];
      int s;
      int gx;
      int gy;
      k = (md == 0) ? 1 : 2;
      if (c >= LW || r < k || c < k) return 0;
      if (md == 0) return img[r-1][c-1];
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = img[r-2+i][c-2+j];
      if (md == 1) begin
         s = p[0][0] + 2*p[0][1] + p[0][2] + 2*p[1][0] + 4*p[1][1] + 2*p[1][2]
           + p[2][0] + 2*p[2][1] + p[2][2];
         return s / 16;
      end
      if (md == 2) begin
         gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
         gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
         if (gx < 0) gx = -gx;
         if (gy < 0) gy = -gy;
         return (gx + gy > 255) ? 255 : gx + gy;
      end
      s = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            if (p[i][j] > s) s = p[i][j];
      return s;
   endfunction

   task automatic step(input bit r_i, input bit vs, input bit hs, input bit pv,
                       input int px, input int md);
      int v;
      @(posedge clk);
      #1;
      ovf_shown = m_ovf;
      if (rst_prev) last_exp = 0;
      rst       = r_i;
      vsync     = vs;
      hsync     = hs;
      pix_valid = pv;
      pix_in    = px[DW-1:0];
      mode      = md[1:0];
      rst_prev  = r_i;
      if (r_i) begin
         while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc) exp_q.pop_back();
         m_r = 0; m_c = 0; m_mode = 0; m_has = 1'b0; m_ovf = 1'b0;
      end else begin
         if (vs) begin
            m_r = 0; m_c = 0; m_mode = md; m_has = 1'b0; m_ovf = 1'b0;
         end else if (hs) begin
            m_c = 0;
            if (m_has) m_r++;
            m_has = 1'b0;
         end
         if (pv) begin
            if (m_c < LW && m_r < 16) img[m_r][m_c] = px;
            v = model_pix(m_r, m_c, m_mode);
            if (m_c >= LW) m_ovf = 1'b1;
            exp_q.push_back('{due: cyc + 3, val: v});
            m_c++;
            m_has = 1'b1;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, $urandom_range(0, 3));
   endtask

   // kind: 0 random, 1 = 10r+c, 2 = constant 100, 3 = vertical step at column 4
   task automatic run_frame(input bit use_vs, input int md, input int h, input int w,
                            input int kind);
      bit vs;
      bit hs;
      int px;
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c++) begin
            vs = use_vs && r == 0 && c == 0;
            hs = vs ? bit'($urandom_range(0, 1)) : (c == 0);
            case (kind)
               1:       px = 10 * r + c;
               2:       px = 100;
               3:       px = (c < 4) ? 0 : 200;
               default: px = $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
            if ((vs || hs) && $urandom_range(0, 3) == 0) begin
               step(1'b0, vs, hs, 1'b0, 0, vs ? md : $urandom_range(0, 3));
               vs = 1'b0;
               hs = 1'b0;
            end
            step(1'b0, vs, hs, 1'b1, px, vs ? md : $urandom_range(0, 3));
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check_eq("out_valid", int'(out_valid), 1);
            check_eq("pix_out", int'(pix_out), exp_q[0].val);
            last_exp = exp_q[0].val;
            void'(exp_q.pop_front());
         end else begin
            check_eq("idle_valid", int'(out_valid), 0);
            check_eq("hold_pix", int'(pix_out), last_exp);
         end
         check_eq("overflow", int'(overflow), int'(ovf_shown));
      end
   end

   initial begin
      // Reset held two cycles with pixels present, then quiet release
      step(1'b1, 1'b0, 1'b0, 1'b1, 55, 2);
      mon_en = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b1, 77, 2);
      idle(3);
      // No VSync yet: must behave as bypass
      run_frame(1'b0, 0, 3, 6, 0);
      run_frame(1'b1, 0, 4, 4, 1);
      run_frame(1'b1, 1, 6, 6, 2);
      run_frame(1'b1, 2, 5, 8, 3);
      run_frame(1'b1, 0, 3, 5, 0);
      run_frame(1'b1, 2, 4, 6, 0);
      // Over-long lines, then a normal frame after the clearing VSync
      run_frame(1'b1, 1, 4, 10, 0);
      run_frame(1'b1, 3, 4, 8, 0);
      // Reset mid-frame, then continue without VSync
      run_frame(1'b1, 3, 2, 7, 0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 9, 1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 9, 1);
      idle(3);
      run_frame(1'b0, 2, 4, 7, 0);
      for (int f = 0; f < 6; f++)
         run_frame(1'b1, $urandom_range(0, 3), $urandom_range(3, 7), $urandom_range(3, 10), 0);
      idle(6);
      check_eq("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
